// File: rtl/hdmi_timing_gen.sv
// Raster timing generator and pixel pacer for the HDMI DDR PHY; registered outputs trail the counters by one cycle.
// Optional colour-bar test pattern (adds tpg_sel) when HDMI_TPG_EN is defined.
module hdmi_timing_gen #(
    parameter int   DW       = 12,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_hsync,
    output logic            out_vsync,
    output logic            out_de,
    output logic            frame_start,
    output logic            underflow,
`ifdef HDMI_TPG_EN
    input  logic            tpg_sel,
`endif
    input  logic            underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [CW-1:0]   vcnt_q, vcnt_d;
    logic [2*DW-1:0] out_data_q, out_data_d;
    logic            out_de_q, out_de_d;
    logic            out_hsync_q, out_hsync_d;
    logic            out_vsync_q, out_vsync_d;
    logic            frame_start_q, frame_start_d;
    logic            underflow_q, underflow_d;

    logic            h_act, v_act, act, hs, vs;
    logic            tpg_on, uf_set;
    logic [2*DW-1:0] pix_word;

`ifdef HDMI_TPG_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int CD    = DW / 3;

    logic [2:0]    bar_rgb;
    logic [DW-1:0] bar_half;

    assign tpg_on = tpg_sel;

    // Bar 0 is white, bar 7 black: each colour channel is the inverted bar-index bit.
    always_comb begin
        bar_rgb  = ~3'(hcnt_q / CW'(BAR_W));
        bar_half = '0;
        for (int i = 0; i < CD; i++) begin
            bar_half[2*CD + i] = bar_rgb[2];
            bar_half[CD + i]   = bar_rgb[1];
            bar_half[i]        = bar_rgb[0];
        end
    end

    assign pix_word = tpg_on ? {bar_half, bar_half} : in_data;
`else
    assign tpg_on   = 1'b0;
    assign pix_word = in_data;
`endif

    // Handshake: a word moves when in_valid & in_ready at a rising clk edge.
    // in_ready depends only on the raster counters, reset and tpg_sel, never on in_valid.
    assign in_ready = act & rst_n & ~tpg_on;

    always_comb begin
        h_act  = (hcnt_q < H_ACT_END);
        v_act  = (vcnt_q < V_ACT_END);
        act    = h_act & v_act;
        hs     = (hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END);
        vs     = (vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END);
        uf_set = act & ~in_valid & ~tpg_on;

        hcnt_d = hcnt_q + CNT_ONE;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
        end

        out_de_d      = act;
        out_hsync_d   = hs ? HS_POL : ~HS_POL;
        out_vsync_d   = vs ? VS_POL : ~VS_POL;
        out_data_d    = (act & (in_valid | tpg_on)) ? pix_word : '0;
        frame_start_d = act & (hcnt_q == '0) & (vcnt_q == '0);
        // A new starvation event outranks a clear in the same cycle.
        underflow_d   = uf_set | (underflow_q & ~underflow_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            out_data_q    <= '0;
            out_de_q      <= 1'b0;
            out_hsync_q   <= ~HS_POL;
            out_vsync_q   <= ~VS_POL;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            out_data_q    <= out_data_d;
            out_de_q      <= out_de_d;
            out_hsync_q   <= out_hsync_d;
            out_vsync_q   <= out_vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_de      = out_de_q;
    assign out_hsync   = out_hsync_q;
    assign out_vsync   = out_vsync_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a 14x7 raster: driver pushes expected pixel words, negedge monitor checks raster and data.
`timescale 1ns/1ps
module tb_hdmi_timing_gen;

    localparam int DW  = 12;
    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int FRM = HT * VT;

    logic            clk           = 1'b0;
    logic            rst_n         = 1'b0;
    logic [2*DW-1:0] in_data       = '0;
    logic            in_valid      = 1'b0;
    logic            underflow_clr = 1'b0;
    logic            tpg_sel       = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] out_data;
    logic            out_hsync, out_vsync, out_de, frame_start, underflow;

    int              tests = 0;
    int              fails = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] word       = 24'h000001;
    bit              hs_pending = 1'b0;
    bit              mon_en     = 1'b0;
    int              kcnt       = 0;
    logic            tpg_prev   = 1'b0;

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .DW(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync),
        .out_de       (out_de),
        .frame_start  (frame_start),
        .underflow    (underflow),
`ifdef HDMI_TPG_EN
        .tpg_sel      (tpg_sel),
`endif
        .underflow_clr(underflow_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*DW-1:0] tpg_word(input int px);
        logic [2:0]    rgb;
        logic [DW-1:0] h;
        rgb = ~3'(px);
        h   = {{4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}};
        return {h, h};
    endfunction

    // Edges since the last reset edge; position 0 is the first cycle after release.
    always @(posedge clk) begin
        if (!rst_n) kcnt <= 0;
        else        kcnt <= kcnt + 1;
        tpg_prev <= tpg_sel;
    end

    task automatic drive_cycle(input logic v, input logic r, input logic c, input logic t);
        @(posedge clk);
        if (hs_pending) word = word + 1;
        #1;
        rst_n         = r;
        in_valid      = v;
        in_data       = word;
        underflow_clr = c;
        tpg_sel       = t;
        #1;
        hs_pending = v && in_ready;
        if (in_ready) exp_q.push_back(v ? word : '0);
    endtask

    task automatic check_uf(input string name, input logic exp);
        @(negedge clk);
        chk(name, underflow, exp);
    endtask

    // Monitor: raster controls from position arithmetic, data from the expected queue.
    int k, p, hc, vc, hp, vp;
    logic exp_de;
    always @(negedge clk) begin
        if (mon_en) begin
            k  = kcnt;
            hc = k % HT;
            vc = (k / HT) % VT;
            chk("in_ready", in_ready, rst_n && hc < 8 && vc < 4 && !tpg_sel);
            if (k == 0) begin
                chk("rst_de", out_de, 0);
                chk("rst_data", out_data, 0);
                chk("rst_hsync", out_hsync, 1);
                chk("rst_vsync", out_vsync, 1);
                chk("rst_frame_start", frame_start, 0);
                chk("rst_underflow", underflow, 0);
            end else begin
                p      = k - 1;
                hp     = p % HT;
                vp     = (p / HT) % VT;
                exp_de = (hp < 8) && (vp < 4);
                chk("de", out_de, exp_de);
                chk("hsync", out_hsync, (hp == 10 || hp == 11) ? 0 : 1);
                chk("vsync", out_vsync, (vp == 5) ? 0 : 1);
                chk("frame_start", frame_start, (p % FRM) == 0);
                if (out_de) begin
                    if (tpg_prev) begin
                        chk("tpg_data", out_data, tpg_word(hp));
                    end else begin
                        chk("data_q_nonempty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) chk("data", out_data, exp_q.pop_front());
                    end
                end else begin
                    chk("blank_data", out_data, 0);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1 mon_en = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Frame 1: release and clean streaming, words 1..32.
        for (int i = 0; i < FRM; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_uf("uf_clean", 1'b0);

        // Frame 2: starve one pixel, clear racing a second starve, then a plain clear.
        for (int i = 0; i < FRM; i++) begin
            drive_cycle(i != 17 && i != 30, 1'b1, i == 30 || i == 40, 1'b0);
            if (i == 20) check_uf("uf_set", 1'b1);
            if (i == 33) check_uf("uf_set_wins", 1'b1);
            if (i == 43) check_uf("uf_cleared", 1'b0);
        end

        // Frame 3: starve, then reset at line 2 pixel 3 for one cycle.
        for (int i = 0; i < 32; i++) begin
            drive_cycle(i != 5, i != 31, 1'b0, 1'b0);
            if (i == 8) check_uf("uf_before_rst", 1'b1);
        end
        for (int i = 0; i < FRM; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);

`ifdef HDMI_TPG_EN
        for (int i = 0; i < FRM; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_uf("uf_tpg", 1'b0);
`endif

        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #7 mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
